// File: rtl/fir_wb_sequencer.sv
// fir_wb_sequencer
// Wishbone master that runs one complete FIR job through the Wishbone-to-FIR
// bridge: writes the length, writes TAPS coefficients, sets ap_start, streams
// len samples to the stream port, then polls ap_ctrl until ap_done is seen.
// Every access is followed by at least one idle cycle, and each access is
// abandoned with an error pulse if no acknowledge arrives within TIMEOUT cycles.
module fir_wb_sequencer #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int TAPS     = 11,
    parameter int TIMEOUT  = 1024,
    parameter int POLL_GAP = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start,
    input  logic [31:0]       len,
    output logic [3:0]        tap_idx,
    input  logic [DATA_W-1:0] tap_data,
    input  logic              smp_valid,
    input  logic [DATA_W-1:0] smp_data,
    output logic              smp_ready,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic              wbm_we_o,
    output logic [3:0]        wbm_sel_o,
    output logic [ADDR_W-1:0] wbm_adr_o,
    output logic [DATA_W-1:0] wbm_dat_o,
    input  logic [DATA_W-1:0] wbm_dat_i,
    input  logic              wbm_ack_i,
    output logic              busy,
    output logic              done,
    output logic              error
);

    // Counter widths: the timeout counter runs 0..TIMEOUT-1, the gap counter 0..POLL_GAP-1.
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);
    localparam logic [3:0]       TAP_LAST = 4'(TAPS - 1);

    // Bridge register map.
    localparam logic [ADDR_W-1:0] ADR_CTRL   = ADDR_W'(32'h0000_0000);
    localparam logic [ADDR_W-1:0] ADR_LEN    = ADDR_W'(32'h0000_0010);
    localparam logic [ADDR_W-1:0] ADR_TAP0   = ADDR_W'(32'h0000_0020);
    localparam logic [ADDR_W-1:0] ADR_STREAM = ADDR_W'(32'h0000_0100);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_LEN,
        ST_WR_TAP,
        ST_WR_START,
        ST_STREAM,
        ST_POLL_WAIT,
        ST_POLL,
        ST_DONE
    } state_t;

    state_t              state_r;
    logic [31:0]         len_r;
    logic [31:0]         smp_cnt_r;
    logic [TMO_W-1:0]    tmo_r;
    logic [GAP_W-1:0]    gap_r;
    logic [3:0]          tap_idx_r;
    logic                cyc_r;
    logic                we_r;
    logic [3:0]          sel_r;
    logic [ADDR_W-1:0]   adr_r;
    logic [DATA_W-1:0]   dat_r;
    logic                smp_ready_r;
    logic                busy_r;
    logic                done_r;
    logic                error_r;

    // Only ap_done (bit 1) of the status word steers the sequencer.
    logic unused_rd_s;
    assign unused_rd_s = ^{wbm_dat_i[DATA_W-1:2], wbm_dat_i[0]};

    assign tap_idx   = tap_idx_r;
    assign smp_ready = smp_ready_r;
    assign wbm_cyc_o = cyc_r;
    assign wbm_stb_o = cyc_r;
    assign wbm_we_o  = we_r;
    assign wbm_sel_o = sel_r;
    assign wbm_adr_o = adr_r;
    assign wbm_dat_o = dat_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign error     = error_r;

    // Sequencer FSM: launches one access per bus state while cyc is low, and
    // completes or aborts it while cyc is high, so accesses never abut.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r     <= ST_IDLE;
            len_r       <= 32'd0;
            smp_cnt_r   <= 32'd0;
            tmo_r       <= {TMO_W{1'b0}};
            gap_r       <= {GAP_W{1'b0}};
            tap_idx_r   <= 4'd0;
            cyc_r       <= 1'b0;
            we_r        <= 1'b0;
            sel_r       <= 4'h0;
            adr_r       <= {ADDR_W{1'b0}};
            dat_r       <= {DATA_W{1'b0}};
            smp_ready_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            smp_ready_r <= 1'b0;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
            if (cyc_r) begin
                if (wbm_ack_i) begin
                    // Access completes: release the bus and advance on this edge.
                    cyc_r <= 1'b0;
                    we_r  <= 1'b0;
                    sel_r <= 4'h0;
                    case (state_r)
                        ST_WR_LEN: begin
                            tap_idx_r <= 4'd0;
                            state_r   <= ST_WR_TAP;
                        end
                        ST_WR_TAP: begin
                            if (tap_idx_r == TAP_LAST) begin
                                state_r <= ST_WR_START;
                            end else begin
                                tap_idx_r <= tap_idx_r + 4'd1;
                            end
                        end
                        ST_WR_START: begin
                            smp_cnt_r <= 32'd0;
                            state_r   <= ST_STREAM;
                        end
                        ST_STREAM: begin
                            smp_cnt_r <= smp_cnt_r + 32'd1;
                            if ((smp_cnt_r + 32'd1) == len_r) begin
                                gap_r   <= {GAP_W{1'b0}};
                                state_r <= ST_POLL_WAIT;
                            end
                        end
                        ST_POLL: begin
                            if (wbm_dat_i[1]) begin
                                state_r <= ST_DONE;
                            end else begin
                                gap_r   <= {GAP_W{1'b0}};
                                state_r <= ST_POLL_WAIT;
                            end
                        end
                        default: begin
                            busy_r  <= 1'b0;
                            state_r <= ST_IDLE;
                        end
                    endcase
                end else if (tmo_r == TMO_LAST) begin
                    // Slave never answered: abandon the job.
                    cyc_r   <= 1'b0;
                    we_r    <= 1'b0;
                    sel_r   <= 4'h0;
                    error_r <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end else begin
                    tmo_r <= tmo_r + TMO_W'(1);
                end
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (start) begin
                            if (len != 32'd0) begin
                                len_r   <= len;
                                busy_r  <= 1'b1;
                                state_r <= ST_WR_LEN;
                            end else begin
                                error_r <= 1'b1;
                            end
                        end
                    end
                    ST_WR_LEN: begin
                        cyc_r <= 1'b1;
                        we_r  <= 1'b1;
                        sel_r <= 4'hF;
                        adr_r <= ADR_LEN;
                        dat_r <= DATA_W'(len_r);
                        tmo_r <= {TMO_W{1'b0}};
                    end
                    ST_WR_TAP: begin
                        cyc_r <= 1'b1;
                        we_r  <= 1'b1;
                        sel_r <= 4'hF;
                        adr_r <= ADR_TAP0 + ADDR_W'({tap_idx_r, 2'b00});
                        dat_r <= tap_data;
                        tmo_r <= {TMO_W{1'b0}};
                    end
                    ST_WR_START: begin
                        cyc_r <= 1'b1;
                        we_r  <= 1'b1;
                        sel_r <= 4'hF;
                        adr_r <= ADR_CTRL;
                        dat_r <= DATA_W'(32'h0000_0001);
                        tmo_r <= {TMO_W{1'b0}};
                    end
                    ST_STREAM: begin
                        // No timeout applies while waiting for a sample.
                        if (smp_valid) begin
                            smp_ready_r <= 1'b1;
                            cyc_r       <= 1'b1;
                            we_r        <= 1'b1;
                            sel_r       <= 4'hF;
                            adr_r       <= ADR_STREAM;
                            dat_r       <= smp_data;
                            tmo_r       <= {TMO_W{1'b0}};
                        end
                    end
                    ST_POLL_WAIT: begin
                        if (gap_r == GAP_LAST) begin
                            state_r <= ST_POLL;
                        end else begin
                            gap_r <= gap_r + GAP_W'(1);
                        end
                    end
                    ST_POLL: begin
                        cyc_r <= 1'b1;
                        we_r  <= 1'b0;
                        sel_r <= 4'hF;
                        adr_r <= ADR_CTRL;
                        dat_r <= {DATA_W{1'b0}};
                        tmo_r <= {TMO_W{1'b0}};
                    end
                    ST_DONE: begin
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                    default: begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
